// File: rtl/jt5205_seq_if.sv
// ROM request/acknowledge bus between the jt5205 sequencer and the sample ROM.
interface jt5205_seq_if #(
  parameter int AW = 16
);
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master (
    output rom_cs,
    output rom_addr,
    input  rom_data,
    input  rom_ok
  );

  modport slave (
    input  rom_cs,
    input  rom_addr,
    output rom_data,
    output rom_ok
  );
endinterface

// File: rtl/jt5205_seq.sv
// jt5205_seq: plays an inclusive ROM byte range into the jt5205 decoder,
// high nibble first, one nibble per decoder strobe. A two-byte buffer
// (B0 playing, B1 prefetched) lets the ROM fetch overlap playback.
module jt5205_seq #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] addr_start,
  input  logic [AW-1:0] addr_end,
  output logic          busy,
  output logic          done,
  output logic          underrun,
  jt5205_seq_if.master  rom,
  input  logic          strobe,
  output logic [3:0]    din,
  output logic          msm_rst
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;
  typedef enum logic [1:0] {PH_H = 2'd0, PH_L = 2'd1, PH_FIN = 2'd2} phase_t;

  state_t        state_r;
  phase_t        phase_r;
  logic [AW-1:0] fptr_r;
  logic [AW-1:0] end_r;
  logic          last_fetched_r;
  logic [7:0]    b0_r;
  logic          b0_v_r;
  logic          b0_last_r;
  logic [7:0]    b1_r;
  logic          b1_v_r;
  logic          b1_last_r;
  logic          busy_r;
  logic          done_r;
  logic          underrun_r;
  logic          rom_cs_r;
  logic [AW-1:0] rom_addr_r;
  logic [3:0]    din_r;
  logic          msm_rst_r;

  logic ack_s;      // ROM acknowledges the outstanding request this cycle
  logic ack_end_s;  // the byte being fetched is the last of the range
  logic play_s;     // a strobe that the playback logic must honour
  logic shift_s;    // B1 moves into B0 after the low nibble plays
  logic to_b0_s;    // incoming ROM byte lands in B0 rather than B1

  assign ack_s     = (state_r == ST_RUN) && rom_cs_r && rom.rom_ok;
  assign ack_end_s = (fptr_r == end_r);
  assign play_s    = (state_r == ST_RUN) && !msm_rst_r && strobe;
  assign shift_s   = play_s && (phase_r == PH_L) && !b0_last_r;
  // When B0 is being vacated by a shift from an empty B1, the fresh byte
  // must go straight to B0 or it would be lost behind an invalid slot.
  assign to_b0_s   = !b0_v_r || (shift_s && !b1_v_r);

  // Sequencer state, ROM fetch, buffer management and nibble playback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      phase_r        <= PH_H;
      fptr_r         <= {AW{1'b0}};
      end_r          <= {AW{1'b0}};
      last_fetched_r <= 1'b0;
      b0_r           <= 8'h00;
      b0_v_r         <= 1'b0;
      b0_last_r      <= 1'b0;
      b1_r           <= 8'h00;
      b1_v_r         <= 1'b0;
      b1_last_r      <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      underrun_r     <= 1'b0;
      rom_cs_r       <= 1'b0;
      rom_addr_r     <= {AW{1'b0}};
      din_r          <= 4'h0;
      msm_rst_r      <= 1'b1;
    end else begin
      done_r <= 1'b0;
      if (stop) begin
        // Abort wins over every other event, including a simultaneous start.
        state_r   <= ST_IDLE;
        phase_r   <= PH_H;
        busy_r    <= 1'b0;
        rom_cs_r  <= 1'b0;
        msm_rst_r <= 1'b1;
        din_r     <= 4'h0;
        b0_v_r    <= 1'b0;
        b1_v_r    <= 1'b0;
      end else if (start) begin
        // Launch (or relaunch) and issue the first request immediately.
        state_r        <= ST_RUN;
        phase_r        <= PH_H;
        busy_r         <= 1'b1;
        fptr_r         <= addr_start;
        end_r          <= addr_end;
        last_fetched_r <= 1'b0;
        b0_v_r         <= 1'b0;
        b1_v_r         <= 1'b0;
        underrun_r     <= 1'b0;
        rom_cs_r       <= 1'b1;
        rom_addr_r     <= addr_start;
        msm_rst_r      <= 1'b1;
        din_r          <= 4'h0;
      end else if (state_r == ST_RUN) begin
        if (rom_cs_r) begin
          if (rom.rom_ok) begin
            rom_cs_r       <= 1'b0;
            fptr_r         <= fptr_r + AW'(1);
            last_fetched_r <= last_fetched_r | ack_end_s;
            msm_rst_r      <= 1'b0;
          end
        end else if (!last_fetched_r && !b1_v_r) begin
          rom_cs_r   <= 1'b1;
          rom_addr_r <= fptr_r;
        end

        if (shift_s) begin
          b0_r      <= b1_r;
          b0_v_r    <= b1_v_r;
          b0_last_r <= b1_last_r;
          b1_v_r    <= 1'b0;
        end

        if (ack_s) begin
          if (to_b0_s) begin
            b0_r      <= rom.rom_data;
            b0_v_r    <= 1'b1;
            b0_last_r <= ack_end_s;
          end else begin
            b1_r      <= rom.rom_data;
            b1_v_r    <= 1'b1;
            b1_last_r <= ack_end_s;
          end
        end

        if (play_s) begin
          case (phase_r)
            PH_H: begin
              if (b0_v_r) begin
                din_r   <= b0_r[7:4];
                phase_r <= PH_L;
              end else begin
                din_r      <= 4'h0;
                underrun_r <= 1'b1;
              end
            end
            PH_L: begin
              din_r   <= b0_r[3:0];
              phase_r <= b0_last_r ? PH_FIN : PH_H;
            end
            PH_FIN: begin
              state_r   <= ST_IDLE;
              phase_r   <= PH_H;
              done_r    <= 1'b1;
              busy_r    <= 1'b0;
              msm_rst_r <= 1'b1;
              din_r     <= 4'h0;
              b0_v_r    <= 1'b0;
              b1_v_r    <= 1'b0;
            end
            default: phase_r <= PH_H;
          endcase
        end
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign underrun     = underrun_r;
  assign rom.rom_cs   = rom_cs_r;
  assign rom.rom_addr = rom_addr_r;
  assign din          = din_r;
  assign msm_rst      = msm_rst_r;

endmodule

// File: tb/tb_jt5205_seq.sv
// Scoreboard bench for jt5205_seq: stimulus queues expected nibbles and ROM
// addresses; a negedge monitor pops and compares as the DUT produces them.
module tb_jt5205_seq;

  typedef struct packed {
    logic [3:0] din;
    logic       done;
    logic       und;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] addr_start;
  logic [15:0] addr_end;
  logic        busy;
  logic        done;
  logic        underrun;
  logic        strobe;
  logic [3:0]  din;
  logic        msm_rst;

  jt5205_seq_if #(.AW(16)) rom_bus ();

  jt5205_seq #(.AW(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .addr_start (addr_start),
    .addr_end   (addr_end),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .rom        (rom_bus),
    .strobe     (strobe),
    .din        (din),
    .msm_rst    (msm_rst)
  );

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  logic [7:0]  mem [logic [15:0]];

  int   n_chk;
  int   n_pass;
  int   cyc;
  int   t0;
  int   lat;
  int   per;
  logic strb_en;

  initial clk = 1'b0;
  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk = n_chk + 1;
    if (act === req) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] d, input logic dn, input logic u);
    exp_t e;
    e.din  = d;
    e.done = dn;
    e.und  = u;
    exp_q.push_back(e);
  endtask

  task automatic launch(input logic [15:0] a0, input logic [15:0] a1, input int l, input int p);
    addr_start = a0;
    addr_end   = a1;
    lat        = l;
    per        = p;
    t0         = cyc + 1;
    strb_en    = 1'b1;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic drain(input int limit);
    for (int i = 0; i < limit && (exp_q.size() != 0 || addr_q.size() != 0); i++) tick(1);
    check("drain", exp_q.size() + addr_q.size(), 0);
  endtask

  // Monitor, ROM responder and strobe generator, all stepped on the negedge.
  initial begin
    logic        strobe_live;
    logic        prev_cs;
    logic [15:0] prev_addr;
    logic        new_req;
    int          rcnt;
    exp_t        e;
    logic [15:0] e_addr;
    strobe = 1'b0;
    strobe_live = 1'b0;
    rom_bus.rom_ok = 1'b0;
    rom_bus.rom_data = 8'h00;
    prev_cs = 1'b0;
    prev_addr = 16'h0000;
    rcnt = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      new_req = rom_bus.rom_cs && (!prev_cs || rom_bus.rom_addr != prev_addr);
      if (new_req) begin
        if (addr_q.size() > 0) begin
          e_addr = addr_q.pop_front();
          check("rom_addr", rom_bus.rom_addr, e_addr);
        end else begin
          check("rom_req_extra", addr_q.size(), 1);
        end
      end
      if (strobe && strobe_live) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("din", din, e.din);
          check("done", done, e.done);
          check("underrun", underrun, e.und);
        end else begin
          check("strobe_extra", exp_q.size(), 1);
        end
      end else if (done) begin
        check("done_spurious", done, 0);
      end
      if (rom_bus.rom_ok) begin
        rom_bus.rom_ok = 1'b0;
        rcnt = 0;
      end else if (rom_bus.rom_cs) begin
        rcnt = new_req ? 1 : rcnt + 1;
        if (rcnt >= lat) begin
          rom_bus.rom_ok = 1'b1;
          rom_bus.rom_data = mem[rom_bus.rom_addr];
        end
      end else begin
        rcnt = 0;
      end
      prev_cs = rom_bus.rom_cs;
      prev_addr = rom_bus.rom_addr;
      strobe_live = busy && !msm_rst;
      strobe = strb_en && ((cyc - t0) % per == per - 1);
    end
  end

  // Directed stimulus.
  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    addr_start = 16'h0000; addr_end = 16'h0000;
    strb_en = 1'b0; lat = 2; per = 32; t0 = 0;
    mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56;
    mem[16'hFFFF] = 8'hA5; mem[16'h0000] = 8'h3C;
    mem[16'h0200] = 8'h9B; mem[16'h0201] = 8'h7E;
    mem[16'h0300] = 8'h1F; mem[16'h0301] = 8'h2E; mem[16'h0302] = 8'h3D; mem[16'h0303] = 8'h4C;
    mem[16'h0400] = 8'h88; mem[16'h0401] = 8'h99; mem[16'h0500] = 8'hC7;
    mem[16'h0600] = 8'h5A; mem[16'h0601] = 8'h6B;
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_rom_cs", rom_bus.rom_cs, 0);
    check("rst_rom_addr", rom_bus.rom_addr, 0);
    check("rst_din", din, 0);
    check("rst_msm_rst", msm_rst, 1);
    rst_n = 1'b1;
    tick(2);

    // Normal playback of three bytes.
    addr_q.push_back(16'h0100); addr_q.push_back(16'h0101); addr_q.push_back(16'h0102);
    push(4'h1, 1'b0, 1'b0); push(4'h2, 1'b0, 1'b0); push(4'h3, 1'b0, 1'b0);
    push(4'h4, 1'b0, 1'b0); push(4'h5, 1'b0, 1'b0); push(4'h6, 1'b0, 1'b0);
    push(4'h0, 1'b1, 1'b0);
    launch(16'h0100, 16'h0102, 2, 32);
    check("t1_busy_n1", busy, 1);
    check("t1_rom_cs_n1", rom_bus.rom_cs, 1);
    drain(400);
    tick(2);
    check("t1_busy_end", busy, 0);
    check("t1_msm_rst_end", msm_rst, 1);
    check("t1_underrun_end", underrun, 0);
    strb_en = 1'b0;
    tick(3);

    // Range crossing the address wrap.
    addr_q.push_back(16'hFFFF); addr_q.push_back(16'h0000);
    push(4'hA, 1'b0, 1'b0); push(4'h5, 1'b0, 1'b0); push(4'h3, 1'b0, 1'b0);
    push(4'hC, 1'b0, 1'b0); push(4'h0, 1'b1, 1'b0);
    launch(16'hFFFF, 16'h0000, 2, 32);
    drain(400);
    strb_en = 1'b0;
    tick(3);

    // Slow ROM starves the decoder.
    addr_q.push_back(16'h0200); addr_q.push_back(16'h0201);
    push(4'h9, 1'b0, 1'b0); push(4'hB, 1'b0, 1'b0);
    push(4'h0, 1'b0, 1'b1); push(4'h0, 1'b0, 1'b1); push(4'h0, 1'b0, 1'b1);
    push(4'h7, 1'b0, 1'b1); push(4'hE, 1'b0, 1'b1); push(4'h0, 1'b1, 1'b1);
    launch(16'h0200, 16'h0201, 100, 20);
    drain(600);
    tick(2);
    check("t3_underrun_sticky", underrun, 1);
    check("t3_busy_end", busy, 0);
    strb_en = 1'b0;
    tick(3);

    // Stop while the third fetch is outstanding.
    addr_q.push_back(16'h0300); addr_q.push_back(16'h0301); addr_q.push_back(16'h0302);
    push(4'h1, 1'b0, 1'b0); push(4'hF, 1'b0, 1'b0);
    launch(16'h0300, 16'h0303, 10, 32);
    tick(69);
    check("t4_pending_cs", rom_bus.rom_cs, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_stop_rom_cs", rom_bus.rom_cs, 0);
    check("t4_stop_msm_rst", msm_rst, 1);
    check("t4_stop_busy", busy, 0);
    tick(100);
    check("t4_din_after", din, 0);
    check("t4_queues", exp_q.size() + addr_q.size(), 0);
    strb_en = 1'b0;
    tick(3);

    // start+stop together, then a relaunch while running.
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("t5_ss_busy", busy, 0);
    check("t5_ss_rom_cs", rom_bus.rom_cs, 0);
    check("t5_ss_msm_rst", msm_rst, 1);
    addr_q.push_back(16'h0400); addr_q.push_back(16'h0401); addr_q.push_back(16'h0500);
    push(4'hC, 1'b0, 1'b0); push(4'h7, 1'b0, 1'b0); push(4'h0, 1'b1, 1'b0);
    launch(16'h0400, 16'h0401, 10, 32);
    tick(24);
    launch(16'h0500, 16'h0500, 10, 32);
    check("t5_relaunch_busy", busy, 1);
    drain(400);
    strb_en = 1'b0;
    tick(3);

    // Asynchronous reset between clock edges mid-playback.
    addr_q.push_back(16'h0600); addr_q.push_back(16'h0601);
    push(4'h5, 1'b0, 1'b0); push(4'hA, 1'b0, 1'b0);
    launch(16'h0600, 16'h0601, 2, 32);
    tick(69);
    check("t6_din_before", din, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_underrun", underrun, 0);
    check("t6_rom_cs", rom_bus.rom_cs, 0);
    check("t6_rom_addr", rom_bus.rom_addr, 0);
    check("t6_din", din, 0);
    check("t6_msm_rst", msm_rst, 1);
    tick(3);
    strb_en = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check("t6_queues", exp_q.size() + addr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
